// File: rtl/mgmt_tx_frame_fifo.sv
// Management TX frame FIFO: byte RAM plus length-header FIFO with commit/abort/drop.
// Optional runt padding to 60 bytes is enabled by defining MGMT_TXFIFO_RUNT_PAD_EN.
module mgmt_tx_frame_fifo #(
  parameter int DATA_DEPTH    = 4096,
  parameter int HDR_DEPTH     = 32,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_commit,
  input  logic                          wr_abort,
  output logic                          wr_drop,
  output logic [$clog2(DATA_DEPTH):0]   wr_free,
  input  logic                          link_up,
  input  logic                          tx_ready,
  output logic                          tx_start,
  output logic                          tx_data_valid,
  output logic [7:0]                    tx_data,
  output logic [$clog2(HDR_DEPTH):0]    frames_pending
);

  localparam int AW  = $clog2(DATA_DEPTH);
  localparam int HW  = $clog2(HDR_DEPTH);
  localparam int LW  = $clog2(MAX_FRAME_LEN + 1);
  localparam int PW  = AW + 1;
  localparam int HPW = HW + 1;
  localparam logic [AW:0] DATA_CAP = PW'(DATA_DEPTH);
  localparam logic [HW:0] HDR_CAP  = HPW'(HDR_DEPTH);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_FRAME_LEN);

`ifdef MGMT_TXFIFO_RUNT_PAD_EN
  typedef enum logic [1:0] {IDLE, POP, SENDING, PAD} state_t;
  localparam logic [LW-1:0] MIN_LEN = LW'(60);
`else
  typedef enum logic [1:0] {IDLE, POP, SENDING} state_t;
`endif

  logic [7:0]    data_mem [DATA_DEPTH];
  logic [LW-1:0] hdr_mem  [HDR_DEPTH];

  logic [AW:0]   tent_q, tent_d;
  logic [AW:0]   comm_q, comm_d;
  logic [AW:0]   rd_q, rd_d;
  logic [LW-1:0] len_q, len_d;
  logic          bad_q, bad_d;
  logic [HW:0]   hwr_q, hwr_d;
  logic [HW:0]   hrd_q, hrd_d;
  logic          drop_q, drop_d;
  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          tx_start_q, tx_start_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
`ifdef MGMT_TXFIFO_RUNT_PAD_EN
  logic [LW-1:0] sent_q, sent_d;
`endif

  logic [AW:0]   used;
  logic          ram_full;
  logic          hdr_full;
  logic          hdr_empty;
  logic          byte_ok;
  logic          byte_bad;
  logic [LW-1:0] len_n;
  logic          bad_n;
  logic          mem_we;
  logic          hdr_we;
  logic [LW-1:0] hdr_len;

  assign used      = tent_q - rd_q;
  assign ram_full  = (used == DATA_CAP);
  assign hdr_full  = ((hwr_q - hrd_q) == HDR_CAP);
  assign hdr_empty = (hwr_q == hrd_q);
  assign byte_ok   = wr_en && !ram_full && (len_q != MAX_LEN);
  assign byte_bad  = wr_en && !byte_ok;
  assign len_n     = len_q + LW'(byte_ok);
  assign bad_n     = bad_q | byte_bad;
  assign hdr_len   = hdr_mem[hrd_q[HW-1:0]];

  always_comb begin
    tent_d     = tent_q;
    comm_d     = comm_q;
    rd_d       = rd_q;
    len_d      = len_q;
    bad_d      = bad_q;
    hwr_d      = hwr_q;
    hrd_d      = hrd_q;
    drop_d     = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    mem_we     = 1'b0;
    hdr_we     = 1'b0;
`ifdef MGMT_TXFIFO_RUNT_PAD_EN
    sent_d     = sent_q;
`endif

    if (wr_abort) begin
      tent_d = comm_q;
      len_d  = '0;
      bad_d  = 1'b0;
    end else begin
      if (byte_ok) begin
        mem_we = 1'b1;
        tent_d = tent_q + 1'b1;
        len_d  = len_n;
      end
      bad_d = bad_n;
      if (wr_commit) begin
        if (bad_n || (len_n != '0 && hdr_full)) begin
          tent_d = comm_q;
          len_d  = '0;
          bad_d  = 1'b0;
          drop_d = 1'b1;
        end else if (len_n != '0) begin
          hdr_we = 1'b1;
          hwr_d  = hwr_q + 1'b1;
          comm_d = tent_d;
          len_d  = '0;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!hdr_empty && tx_ready && link_up)
          state_d = POP;
      end
      POP: begin
        hrd_d      = hrd_q + 1'b1;
        rd_d       = rd_q + 1'b1;
        cnt_d      = hdr_len - 1'b1;
        tx_start_d = 1'b1;
        tx_valid_d = 1'b1;
        tx_data_d  = data_mem[rd_q[AW-1:0]];
        state_d    = SENDING;
`ifdef MGMT_TXFIFO_RUNT_PAD_EN
        sent_d     = LW'(1);
`endif
      end
      SENDING: begin
        if (cnt_q != '0) begin
          rd_d       = rd_q + 1'b1;
          cnt_d      = cnt_q - 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = data_mem[rd_q[AW-1:0]];
`ifdef MGMT_TXFIFO_RUNT_PAD_EN
          sent_d     = sent_q + 1'b1;
`endif
        end else begin
`ifdef MGMT_TXFIFO_RUNT_PAD_EN
          if (sent_q < MIN_LEN) begin
            tx_valid_d = 1'b1;
            sent_d     = sent_q + 1'b1;
            state_d    = PAD;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef MGMT_TXFIFO_RUNT_PAD_EN
      PAD: begin
        if (sent_q < MIN_LEN) begin
          tx_valid_d = 1'b1;
          sent_d     = sent_q + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // link loss drops everything, including a frame mid-transmit
    if (!link_up) begin
      tent_d     = '0;
      comm_d     = '0;
      rd_d       = '0;
      len_d      = '0;
      bad_d      = 1'b0;
      hwr_d      = '0;
      hrd_d      = '0;
      drop_d     = 1'b0;
      state_d    = IDLE;
      cnt_d      = '0;
      tx_start_d = 1'b0;
      tx_valid_d = 1'b0;
      tx_data_d  = 8'h00;
      mem_we     = 1'b0;
      hdr_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      data_mem[tent_q[AW-1:0]] <= wr_data;
    if (hdr_we)
      hdr_mem[hwr_q[HW-1:0]] <= len_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tent_q     <= '0;
      comm_q     <= '0;
      rd_q       <= '0;
      len_q      <= '0;
      bad_q      <= 1'b0;
      hwr_q      <= '0;
      hrd_q      <= '0;
      drop_q     <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
`ifdef MGMT_TXFIFO_RUNT_PAD_EN
      sent_q     <= '0;
`endif
    end else begin
      tent_q     <= tent_d;
      comm_q     <= comm_d;
      rd_q       <= rd_d;
      len_q      <= len_d;
      bad_q      <= bad_d;
      hwr_q      <= hwr_d;
      hrd_q      <= hrd_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
`ifdef MGMT_TXFIFO_RUNT_PAD_EN
      sent_q     <= sent_d;
`endif
    end
  end

  assign wr_drop        = drop_q;
  assign wr_free        = DATA_CAP - used;
  assign frames_pending = hwr_q - hrd_q;
  assign tx_start       = tx_start_q;
  assign tx_data_valid  = tx_valid_q;
  assign tx_data        = tx_data_q;

endmodule
